// File: rtl/systolic_pkg.sv
// Shared defaults and state type for the systolic array output collector.
package systolic_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_COL   = 32;
    localparam int DEF_DEPTH = 4;

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } collector_state_t;

endpackage

// File: rtl/collector_fifo.sv
// Per-column FIFO: power-of-two depth with wrapping pointers and an occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module collector_fifo #(
    parameter int width = 16,
    parameter int depth = 4
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [width-1:0]         din,
    output logic [width-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(depth):0]   count
);

    localparam int AW = $clog2(depth);

    logic [width-1:0] r_mem [depth];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign full  = (r_count == (AW+1)'(depth));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_rptr];

    assign w_wr = push && (!full || pop);
    assign w_rd = pop && !empty;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is data only: no reset, written whenever a push is accepted.
    always_ff @(posedge clk) begin
        if (w_wr && !clear) r_mem[r_wptr] <= din;
    end

endmodule

// File: rtl/systolic_collector.sv
// De-skews per-column systolic array outputs into aligned rows via per-column FIFOs.
// Optional build macro COLLECTOR_RELU_EN clamps negative words to zero on write.
module systolic_collector
    import systolic_pkg::*;
#(
    parameter int width = DEF_WIDTH,
    parameter int col   = DEF_COL,
    parameter int depth = DEF_DEPTH
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               clear,
    input  logic               out_en       [col-1:0],
    input  logic [width-1:0]   systolic_out [col-1:0],
    input  logic               conv_finish,
    output logic               row_valid,
    input  logic               row_ready,
    output logic [width-1:0]   row_data     [col-1:0],
    output logic [15:0]        row_count,
    output logic               overflow,
    output logic               done
);

    localparam int CW = $clog2(depth) + 1;

`ifdef COLLECTOR_RELU_EN
    function automatic logic [width-1:0] relu(input logic [width-1:0] w);
        return w[width-1] ? '0 : w;
    endfunction
`endif

    collector_state_t r_state;
    collector_state_t w_state_nxt;

    logic [col-1:0] w_full;
    logic [col-1:0] w_empty;
    logic [col-1:0] w_cnt_zero;
    logic [col-1:0] w_drop;
    logic           w_pop;
    logic [15:0]    r_row_count;
    logic           r_overflow;

    assign row_valid = &(~w_empty);
    assign w_pop     = row_valid && row_ready;

    for (genvar c = 0; c < col; c++) begin : g_col
        logic [width-1:0] w_din;
        logic [CW-1:0]    w_count;

`ifdef COLLECTOR_RELU_EN
        assign w_din = relu(systolic_out[c]);
`else
        assign w_din = systolic_out[c];
`endif

        collector_fifo #(
            .width (width),
            .depth (depth)
        ) u_fifo (
            .clk   (clk),
            .nrst  (nrst),
            .clear (clear),
            .push  (out_en[c]),
            .pop   (w_pop),
            .din   (w_din),
            .dout  (row_data[c]),
            .full  (w_full[c]),
            .empty (w_empty[c]),
            .count (w_count)
        );

        assign w_cnt_zero[c] = (w_count == '0);
        assign w_drop[c]     = out_en[c] && w_full[c] && !w_pop;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_row_count <= '0;
            r_overflow  <= 1'b0;
        end else if (clear) begin
            r_row_count <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_pop)   r_row_count <= r_row_count + 1'b1;
            if (|w_drop) r_overflow  <= 1'b1;
        end
    end

    assign row_count = r_row_count;
    assign overflow  = r_overflow;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) r_state <= COLLECT;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        done        = 1'b0;
        if (clear) begin
            w_state_nxt = COLLECT;
        end else begin
            case (r_state)
                COLLECT: if (conv_finish) w_state_nxt = DRAIN;
                DRAIN:   w_state_nxt = DRAIN;
                default: w_state_nxt = COLLECT;
            endcase
        end
        if (r_state == DRAIN) done = &w_cnt_zero;
    end

endmodule

// File: tb/tb_systolic_collector.sv
// Directed bench for systolic_collector with col=4, depth=4, width=16.
module tb_systolic_collector;

    localparam int W = 16;
    localparam int C = 4;
    localparam int D = 4;

    logic          clk;
    logic          nrst;
    logic          clear;
    logic          out_en       [C-1:0];
    logic [W-1:0]  systolic_out [C-1:0];
    logic          conv_finish;
    logic          row_valid;
    logic          row_ready;
    logic [W-1:0]  row_data     [C-1:0];
    logic [15:0]   row_count;
    logic          overflow;
    logic          done;

    int n_chk = 0;
    int n_err = 0;

    systolic_collector #(
        .width (W),
        .col   (C),
        .depth (D)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .clear        (clear),
        .out_en       (out_en),
        .systolic_out (systolic_out),
        .conv_finish  (conv_finish),
        .row_valid    (row_valid),
        .row_ready    (row_ready),
        .row_data     (row_data),
        .row_count    (row_count),
        .overflow     (overflow),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        for (int c = 0; c < C; c++) out_en[c] = 1'b0;
    endtask

    task automatic wr(input int c, input logic [W-1:0] v);
        out_en[c]       = 1'b1;
        systolic_out[c] = v;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    logic [W-1:0] relu_exp;

    initial begin
        nrst        = 1'b0;
        clear       = 1'b0;
        conv_finish = 1'b0;
        row_ready   = 1'b0;
        for (int c = 0; c < C; c++) begin
            out_en[c]       = 1'b0;
            systolic_out[c] = '0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_row_valid", row_valid, 0);
        chk("rst_row_count", row_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_done", done, 0);
        nrst = 1'b1;
        tick();

        // Skewed arrival, one column per cycle
        row_ready = 1'b1;
        for (int c = 0; c < C; c++) begin
            idle();
            wr(c, W'((c + 1) * 10));
            tick();
            if (c == 2) chk("skew_not_ready", row_valid, 0);
        end
        idle();
        chk("skew_row_valid", row_valid, 1);
        chk("skew_d0", row_data[0], 10);
        chk("skew_d1", row_data[1], 20);
        chk("skew_d2", row_data[2], 30);
        chk("skew_d3", row_data[3], 40);
        tick();
        chk("skew_row_count", row_count, 1);
        chk("skew_popped", row_valid, 0);

        // Overflow on column 0 with no consumer
        row_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            idle();
            wr(0, W'(i));
            tick();
            if (i == 4) chk("ovf_before", overflow, 0);
        end
        idle();
        chk("ovf_set", overflow, 1);
        wr(1, 100); wr(2, 200); wr(3, 300);
        tick();
        idle();
        chk("ovf_row_valid", row_valid, 1);
        chk("ovf_head", row_data[0], 1);
        tick();
        chk("ovf_stable", row_data[0], 1);
        chk("ovf_sticky", overflow, 1);
        do_clear();
        chk("clr_overflow", overflow, 0);
        chk("clr_row_count", row_count, 0);
        chk("clr_row_valid", row_valid, 0);

        // Full FIFO with simultaneous write and pop
        for (int i = 0; i < 4; i++) begin
            idle();
            wr(0, W'(11 + i));
            tick();
        end
        idle();
        wr(1, 21); wr(2, 31); wr(3, 41);
        tick();
        idle();
        chk("fullpop_valid", row_valid, 1);
        wr(0, 15);
        row_ready = 1'b1;
        tick();
        idle();
        row_ready = 1'b0;
        chk("fullpop_ovf", overflow, 0);
        chk("fullpop_count", row_count, 1);
        wr(0, 99);
        tick();
        idle();
        chk("fullpop_still_full", overflow, 1);
        wr(1, 22); wr(2, 32); wr(3, 42);
        tick();
        idle();
        chk("fullpop_head", row_data[0], 12);
        do_clear();

        // Drain after conv_finish
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < C; c++) wr(c, W'(50 + r));
            tick();
        end
        idle();
        conv_finish = 1'b1;
        tick();
        conv_finish = 1'b0;
        chk("drain_pending", done, 0);
        row_ready = 1'b1;
        tick();
        chk("drain_cnt1", row_count, 1);
        chk("drain_done1", done, 0);
        tick();
        chk("drain_cnt2", row_count, 2);
        chk("drain_done2", done, 1);
        row_ready = 1'b0;
        conv_finish = 1'b1;
        tick();
        conv_finish = 1'b0;
        chk("drain_refinish", done, 1);

        // Clear wins over simultaneous writes and conv_finish
        for (int c = 0; c < C; c++) wr(c, 16'h00AA);
        conv_finish = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        conv_finish = 1'b0;
        idle();
        chk("clrpri_valid", row_valid, 0);
        chk("clrpri_done", done, 0);
        chk("clrpri_count", row_count, 0);

        // Negative word handling
`ifdef COLLECTOR_RELU_EN
        relu_exp = 16'h0000;
`else
        relu_exp = 16'hFFF6;
`endif
        wr(0, 16'hFFF6); wr(1, 16'h0005); wr(2, 16'h0001); wr(3, 16'h0001);
        tick();
        idle();
        chk("relu_neg", row_data[0], relu_exp);
        chk("relu_pos", row_data[1], 16'h0005);
        row_ready = 1'b1;
        tick();
        row_ready = 1'b0;
        chk("relu_count", row_count, 1);

        // Asynchronous reset mid-row
        for (int c = 0; c < 3; c++) begin
            idle();
            wr(c, W'(c + 1));
            tick();
        end
        idle();
        chk("midrst_partial", row_valid, 0);
        #2;
        nrst = 1'b0;
        #1;
        chk("midrst_valid", row_valid, 0);
        chk("midrst_count", row_count, 0);
        @(negedge clk);
        nrst = 1'b1;
        tick();
        wr(0, 7); wr(1, 8); wr(2, 9); wr(3, 10);
        tick();
        idle();
        chk("midrst_row_valid", row_valid, 1);
        chk("midrst_d0", row_data[0], 7);
        chk("midrst_d3", row_data[3], 10);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/systolic_collector.md
SYSTOLIC_COLLECTOR -- requirements
Module: systolic_collector

Interface
REQ-001 The block SHALL have parameter width, default 16: bits per array output word.
REQ-002 The block SHALL have parameter col, default 32: number of array columns.
REQ-003 The block SHALL have parameter depth, default 4, a power of two >= 2: entries per column FIFO.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port nrst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port clear, input, 1 bit: synchronous flush of all state, for use before each convolution.
REQ-007 The block SHALL have port out_en, input, unpacked [col-1:0] of 1 bit: per-column array output strobe.
REQ-008 The block SHALL have port systolic_out, input, unpacked [col-1:0] of width bits: per-column array result.
REQ-009 The block SHALL have port conv_finish, input, 1 bit: convolution-complete pulse from the array control.
REQ-010 The block SHALL have port row_valid, output, 1 bit: a column-aligned result row is available.
REQ-011 The block SHALL have port row_ready, input, 1 bit: the downstream consumer accepts the row.
REQ-012 The block SHALL have port row_data, output, unpacked [col-1:0] of width bits: the aligned result row.
REQ-013 The block SHALL have port row_count, output, 16 bits: the number of rows accepted since reset or clear.
REQ-014 The block SHALL have port overflow, output, 1 bit: sticky flag for a dropped write.
REQ-015 The block SHALL have port done, output, 1 bit: conv_finish has been seen and every FIFO has drained.

Function
REQ-016 Each column c SHALL own one FIFO; when out_en[c]=1 and that FIFO is not full, systolic_out[c] SHALL be written to it that cycle.
REQ-017 Columns SHALL be written independently, so the diagonal (skewed) arrival of outputs across columns is de-skewed by the FIFOs.
REQ-018 row_valid SHALL be 1 exactly when all col FIFOs are non-empty; row_data[c] SHALL be the head entry of FIFO c.
REQ-019 A row SHALL be transferred when row_valid=1 and row_ready=1 in the same cycle: every FIFO pops once and row_count increments by 1, wrapping at 2^16.
REQ-020 Write-to-read latency SHALL be one cycle: a word written at edge N is visible at the FIFO head after edge N, so the earliest row_valid follows that edge.
REQ-021 row_data SHALL remain stable while row_valid=1 and row_ready=0.
REQ-022 When a FIFO is full, out_en[c]=1, and no pop occurs that cycle, the write SHALL be dropped and overflow set to 1; overflow stays 1 until reset or clear.
REQ-023 When a FIFO is full, out_en[c]=1, and a pop occurs in the same cycle, both the pop and the write SHALL occur, the FIFO occupancy stays at depth, and overflow is not set.
REQ-024 FIFO read and write pointers SHALL each be log2(depth) bits and wrap modulo depth; each occupancy count SHALL be log2(depth)+1 bits.
REQ-025 The block SHALL use a 2-state machine, state COLLECT and state DRAIN.
REQ-026 COLLECT SHALL be the reset state; the machine SHALL move COLLECT -> DRAIN on conv_finish=1.
REQ-027 In DRAIN, done SHALL be 1 while every FIFO count is 0, and 0 otherwise.
REQ-028 DRAIN SHALL return to COLLECT only on clear.
REQ-029 conv_finish=1 while already in DRAIN SHALL be ignored.
REQ-030 clear SHALL take priority over any write, pop, or conv_finish in the same cycle.

Reset
REQ-031 On nrst=0, asynchronously, all FIFO pointers and counts SHALL be 0, and the state SHALL be COLLECT.
REQ-032 On nrst=0, asynchronously, row_valid=0, row_count=0, overflow=0, and done=0.
REQ-033 FIFO storage SHALL NOT require reset, and row_data is don't-care while row_valid=0.
REQ-034 clear=1 SHALL produce the same state as reset, one cycle later, synchronously.
REQ-035 A reset or clear asserted mid-row SHALL discard all partially collected columns.

Configuration
REQ-036 When macro COLLECTOR_RELU_EN is defined, each word SHALL be treated as two's-complement and written to its FIFO as max(word, 0), so negative words become 0.
REQ-037 When COLLECTOR_RELU_EN is not defined, words SHALL be stored unmodified.
REQ-038 Latency SHALL be identical with and without COLLECTOR_RELU_EN.

Structure
REQ-039 The shared package systolic_pkg SHALL hold the default width, col, and depth constants.
REQ-040 systolic_pkg SHALL hold the state enum typedef (COLLECT, DRAIN).
REQ-041 The per-column FIFO SHALL be one sub-module, collector_fifo (parameters width and depth; ports push, pop, din, dout, full, empty, count), instantiated col times by a generate loop.

Verification
REQ-042 Bench config col=4, depth=4: skewed writes with column c strobed at cycle c, values 10,20,30,40, then row_ready=1 -> row_valid rises the cycle after the column-3 write, row_data={10,20,30,40}, and row_count=1.
REQ-043 row_ready=0 while 5 writes arrive on column 0 -> 4 are stored, the 5th is dropped, and overflow=1.
REQ-044 Column 0 full, with an out_en[0] write and a row pop in the same cycle -> count stays 4 and overflow stays 0.
REQ-045 conv_finish with 2 rows pending, then 2 accepted rows -> done=0 until the second pop, then done=1.
REQ-046 With COLLECTOR_RELU_EN defined, write 16'hFFF6 (-10) and 16'h0005 -> stored and output values 0 and 5.
REQ-047 nrst low mid-collection with 3 of 4 columns written -> row_valid=0, row_count=0, and after release the next full row arrives intact.
